sqrt_dp: RTL
============

Name: sqrt_dp

Overview:
- Datapath stage for the iterative integer square-root unit; sits directly downstream of the square-root controller FSM.
- Consumes the controller's restart/mux/enable strobes, holds the operand, accumulator and result registers, and returns the running square to the controller for its compare.
- Algorithm: S=(k+1)^2, D=2k; loop while S<=X (D+=2; S+=D; S+=1); result R=D>>1.
- Also owns the result-valid flag seen by the consumer.

Parameters:
- XW, 8, operand width; X in [0, 2^XW-1].
- SW, XW+1, width of S, D, operand regs A/B and adder (S max 2^XW).
- RW, XW/2, result width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- x_i  in  XW  operand; sampled only when restart_flag_i=1.
- restart_flag_i  in  1  load initial values.
- mux_ctrl1_i  in  1  operand A select: 0=S, 1=D.
- mux_ctrl2_i  in  2  operand B select: 00=D, 01=const 1, 10=const 2, 11=const 0.
- op_en_i  in  1  latch A/B from muxes.
- d_en_i  in  1  D <= A+B.
- s_en_i  in  1  S <= A+B.
- r_en_i  in  1  R <= D>>1 and set r_valid_o.
- s_o  out  SW  current S register, to controller compare.
- x_o  out  XW  latched operand, to controller compare.
- r_o  out  RW  result register.
- r_valid_o  out  1  result valid, sticky.

Behaviour:
- Reset (async, rst_i=1): S=1, D=0, A=0, B=0, X=0, R=0, r_valid_o=0. Reset mid-computation aborts with no partial update of R.
- All registers update on the rising clk_i edge. Outputs are the direct register values with no combinational path from the inputs.
- restart_flag_i=1: S<=1, D<=0, A<=0, B<=0, X<=x_i, r_valid_o<=0; R holds its value. restart overrides every other enable asserted in the same cycle.
- op_en_i=1: A<=mux1 value and B<=mux2 value, using the S/D values before this edge.
- Adder: sum=A+B, combinational, SW bits, carry-out discarded. Legal sequences never overflow (S<=2^XW, D<=2^(XW/2+1)).
- d_en_i and s_en_i both write sum. Both asserted together: both load sum.
- r_en_i=1: R<=D[RW:1], r_valid_o<=1. r_valid_o stays 1 until the next restart or reset.
- Enables other than restart are independent; any combination is legal.
- Expected strobe sequence per iteration (one strobe per cycle):
  - op_en with A=D, B=2
  - d_en
  - op_en with A=S, B=D
  - s_en
  - op_en with A=S, B=1
  - s_en
- Between restart and the final r_en, x_i changes have no effect. x_o and s_o are stable during the controller compare cycle.
- Boundaries:
  - X=0: no iterations, R=0.
  - X=2^XW-1: final S=2^XW fits in SW bits, R=2^(XW/2)-1.
  - Perfect squares terminate with R=sqrt(X) exactly.

Decomposition:
- Package sqrt_pkg: XW/SW/RW defaults, mux_ctrl2 encoding constants (SEL_D, SEL_ONE, SEL_TWO, SEL_ZERO), S_INIT=1, D_INIT=0.
- Optional sub-module sqrt_opmux: two-input A mux plus four-input B mux feeding the operand regs. The rest stays flat.

Test Plan:
- Reset check: rst_i pulse → s_o=1, D=0, r_o=0, r_valid_o=0, asynchronously without a clock edge.
- Full sequence with x_i=4 → s_o steps 1→4→9, D steps 0→2→4 → r_o=2, r_valid_o=1 one cycle after r_en.
- x_i=0 → restart, then r_en with no iteration → r_o=0. x_i=255 → 15 iterations → s_o=256, r_o=15.
- x_i=8 (non-square) → r_o=2. x_i toggled to 200 mid-run → x_o stays 8, r_o still 2.
- restart_flag asserted together with d_en/s_en/r_en → S=1, D=0, r_valid_o=0; R unchanged from the prior result.
- rst_i asserted mid-iteration (D=2, S=4) → all registers return to reset values immediately; a following x_i=9 run gives r_o=3.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared widths, B-operand select encodings and init values
// for the iterative integer square-root datapath.
package sqrt_pkg;

  localparam int SQ_XW = 8;
  localparam int SQ_SW = SQ_XW + 1;
  localparam int SQ_RW = SQ_XW / 2;

  localparam logic [1:0] SEL_D    = 2'b00;
  localparam logic [1:0] SEL_ONE  = 2'b01;
  localparam logic [1:0] SEL_TWO  = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam int S_INIT = 1;
  localparam int D_INIT = 0;

endpackage

// File: rtl/sqrt_opmux.sv
// Operand selection: A picks S or D, B picks D or a
// small constant, both feeding the operand registers.
module sqrt_opmux
  import sqrt_pkg::*;
#(
  parameter int SW = SQ_SW
) (
  input  logic [SW-1:0] s_i,
  input  logic [SW-1:0] d_i,
  input  logic          mux_ctrl1_i,
  input  logic [1:0]    mux_ctrl2_i,
  output logic [SW-1:0] a_o,
  output logic [SW-1:0] b_o
);

  always_comb begin
    a_o = mux_ctrl1_i ? d_i : s_i;
  end

  always_comb begin
    b_o = '0;
    unique case (mux_ctrl2_i)
      SEL_D:    b_o = d_i;
      SEL_ONE:  b_o = SW'(1);
      SEL_TWO:  b_o = SW'(2);
      SEL_ZERO: b_o = '0;
      default:  b_o = '0;
    endcase
  end

endmodule

// File: rtl/sqrt_dp.sv
// Square-root datapath: S/D accumulators, operand regs,
// shared adder, latched operand and sticky result.
module sqrt_dp
  import sqrt_pkg::*;
#(
  parameter int XW = SQ_XW,
  parameter int SW = XW + 1,
  parameter int RW = XW / 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [XW-1:0] x_i,
  input  logic          restart_flag_i,
  input  logic          mux_ctrl1_i,
  input  logic [1:0]    mux_ctrl2_i,
  input  logic          op_en_i,
  input  logic          d_en_i,
  input  logic          s_en_i,
  input  logic          r_en_i,
  output logic [SW-1:0] s_o,
  output logic [XW-1:0] x_o,
  output logic [RW-1:0] r_o,
  output logic          r_valid_o
);

  logic [SW-1:0] s_q, d_q, a_q, b_q;
  logic [SW-1:0] a_d, b_d, sum;
  logic [XW-1:0] x_q;
  logic [RW-1:0] r_q;
  logic          rv_q;

  sqrt_opmux #(.SW(SW)) u_opmux (
    .s_i         (s_q),
    .d_i         (d_q),
    .mux_ctrl1_i (mux_ctrl1_i),
    .mux_ctrl2_i (mux_ctrl2_i),
    .a_o         (a_d),
    .b_o         (b_d)
  );

  // Carry-out dropped: legal sequences stay within SW bits.
  assign sum = a_q + b_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_q  <= SW'(S_INIT);
      d_q  <= SW'(D_INIT);
      a_q  <= '0;
      b_q  <= '0;
      x_q  <= '0;
      r_q  <= '0;
      rv_q <= 1'b0;
    end else if (restart_flag_i) begin
      s_q  <= SW'(S_INIT);
      d_q  <= SW'(D_INIT);
      a_q  <= '0;
      b_q  <= '0;
      x_q  <= x_i;
      rv_q <= 1'b0;
    end else begin
      if (op_en_i) begin
        a_q <= a_d;
        b_q <= b_d;
      end
      if (d_en_i) d_q <= sum;
      if (s_en_i) s_q <= sum;
      if (r_en_i) begin
        r_q  <= d_q[RW:1];
        rv_q <= 1'b1;
      end
    end
  end

  assign s_o       = s_q;
  assign x_o       = x_q;
  assign r_o       = r_q;
  assign r_valid_o = rv_q;

endmodule
